// File: rtl/intt_half_scaler.sv
// intt_half_scaler
// ----------------
// Walks a coefficient memory in place and multiplies every entry by 2^-k mod Q.
// One coefficient costs 3+k cycles: a read, a capture, k halving steps and a write.
// A modular halving step maps x to x/2 when x is even and to (x>>1)+(Q+1)/2 when x is odd.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle request to scale the whole memory (ignored while busy)
//   shift_cnt  : number of halvings k, latched when start is accepted
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at the end of a pass
//   err        : sticky flag, set when a read word is >= Q, cleared by the next start
//   rd_en/rd_addr, rd_data : read port, rd_data valid one cycle after rd_en
//   wr_en/wr_addr/wr_data  : write port
module intt_half_scaler #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 10,
  parameter int Q          = 12289
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            shift_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam logic [DATA_WIDTH-1:0] HALF_Q   = DATA_WIDTH'((Q + 1) / 2);
  localparam logic [DATA_WIDTH:0]   Q_EXT    = (DATA_WIDTH + 1)'(Q);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_HALF = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Multiply by 2^-1 mod Q: odd values borrow Q before halving, folded into +(Q+1)/2.
  function automatic logic [DATA_WIDTH-1:0] half_mod(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] sh;
    sh = x >> 1;
    if (x[0]) begin
      half_mod = sh + HALF_Q;
    end else begin
      half_mod = sh;
    end
  endfunction

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   idx_q,     idx_d;
  logic [DATA_WIDTH-1:0]   acc_q,     acc_d;
  logic [3:0]              k_q,       k_d;
  logic [3:0]              rem_q,     rem_d;
  logic                    err_q,     err_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    rd_en_q,   rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   half_acc_s;

  assign half_acc_s = half_mod(acc_q);

  // Next-state logic; strobes are computed one state ahead so the outputs come straight from flops.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    k_d       = k_q;
    rem_d     = rem_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d       = shift_cnt;
          idx_d     = {ADDR_WIDTH{1'b0}};
          err_d     = 1'b0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = {ADDR_WIDTH{1'b0}};
          state_d   = S_RD;
        end else begin
          busy_d    = 1'b0;
        end
      end

      S_RD: begin
        state_d = S_CAP;
      end

      S_CAP: begin
        acc_d = rd_data;
        rem_d = k_q;
        if ({1'b0, rd_data} >= Q_EXT) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (k_q != 4'd0) begin
          state_d = S_HALF;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rd_data;
          state_d   = S_WR;
        end
      end

      S_HALF: begin
        acc_d = half_acc_s;
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = half_acc_s;
          state_d   = S_WR;
        end else begin
          state_d   = S_HALF;
        end
      end

      S_WR: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + ADDR_ONE;
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q + ADDR_ONE;
          state_d   = S_RD;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= {ADDR_WIDTH{1'b0}};
      acc_q     <= {DATA_WIDTH{1'b0}};
      k_q       <= 4'd0;
      rem_q     <= 4'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= {ADDR_WIDTH{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_WIDTH{1'b0}};
      wr_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_intt_half_scaler.sv
// Bench for intt_half_scaler with a 4-word memory (ADDR_WIDTH=2).
// Expected behaviour is derived from modular arithmetic (x * 6145^k mod Q) and the
// per-coefficient period of 3+k cycles, checked every cycle by one compare process.
module tb_intt_half_scaler;

  localparam int DW = 14;
  localparam int AW = 2;
  localparam int N  = 4;
  localparam int Q  = 12289;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    shift_cnt;
  logic          busy, done, err, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  intt_half_scaler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Q(Q)) dut (
    .clk(clk), .rst(rst), .start(start), .shift_cnt(shift_cnt),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // x * 2^-k mod Q using the inverse of two (6145) rather than the bit rule.
  function automatic longint scale(input longint x, input int k);
    longint r;
    r = x % Q;
    for (int j = 0; j < k; j++) r = (r * 6145) % Q;
    return r;
  endfunction

  // Memory responder: one-cycle read latency, loads requested by the stimulus.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] pre [N];
  int load_seq = 0;
  int load_seen = 0;
  always @(posedge clk) begin
    if (load_seq != load_seen) begin
      mem       <= pre;
      load_seen <= load_seq;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  // Reference model state and per-cycle compare.
  bit            active = 1'b0;
  bit            err_m  = 1'b0;
  int            t = 0;
  int            k_m = 0;
  int            done_t = -1;
  logic [DW-1:0] init_m [N];
  int            per, ci, cr;
  bit            in_pass;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      err_m  = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_data", wr_data, 0);
    end else if (active) begin
      per     = 3 + k_m;
      ci      = t / per;
      cr      = t % per;
      in_pass = (t < N * per);
      if (in_pass && cr == 2 && init_m[ci] >= Q) err_m = 1'b1;
      chk("busy", busy, 1);
      chk("done", done, (t == N * per) ? 1 : 0);
      chk("rd_en", rd_en, (in_pass && cr == 0) ? 1 : 0);
      chk("wr_en", wr_en, (in_pass && cr == per - 1) ? 1 : 0);
      chk("err", err, err_m);
      if (in_pass && cr == 0) chk("rd_addr", rd_addr, ci);
      if (in_pass && cr == per - 1) begin
        chk("wr_addr", wr_addr, ci);
        if (init_m[ci] < Q) chk("wr_data", wr_data, scale(init_m[ci], k_m));
      end
      if (done) done_t = t;
      t++;
      if (t > N * per) active = 1'b0;
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rd_en", rd_en, 0);
      chk("idle_wr_en", wr_en, 0);
      chk("idle_err", err, err_m);
      if (start) begin
        active = 1'b1;
        t      = 0;
        k_m    = shift_cnt;
        init_m = mem;
        err_m  = 1'b0;
        done_t = -1;
      end
    end
  end

  // Stimulus runs at posedge+1 so the compare process sees stable inputs.
  task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic [DW-1:0] d);
    pre[0] = a; pre[1] = b; pre[2] = c; pre[3] = d;
    load_seq++;
    @(posedge clk); #1;
  endtask

  task automatic kick(input int kk);
    shift_cnt = 4'(kk);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_pass(input int kk, input bit noise);
    int n;
    kick(kk);
    n = 0;
    while (active && n < 1000) begin
      if (noise && t < N * (3 + kk)) begin
        start     = 1'($urandom_range(0, 1));
        shift_cnt = 4'($urandom_range(0, 15));
      end else begin
        start     = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (n >= 1000) chk("pass_timeout", n, 0);
  endtask

  function automatic logic [DW-1:0] rnd_coef(input bit allow_bad);
    if (allow_bad && $urandom_range(0, 7) == 0) return DW'($urandom_range(Q, 16383));
    return DW'($urandom_range(0, Q - 1));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d tests, expected completion", tests);
    $fatal(1);
  end

  initial begin
    int n;
    int kr;
    rst = 1'b1; start = 1'b0; shift_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Model pins
    chk("model_1_k10", scale(1, 10), 12277);
    chk("model_1024_k10", scale(1024, 10), 1);
    chk("model_1_k1", scale(1, 1), 6145);

    // k=1 basic pass
    load(14'd1, 14'd2, 14'd12288, 14'd0);
    run_pass(1, 1'b0);
    chk("k1_mem0", mem[0], 6145);
    chk("k1_mem1", mem[1], 1);
    chk("k1_mem2", mem[2], 6144);
    chk("k1_mem3", mem[3], 0);
    chk("k1_done_cycle", done_t, 16);

    // k=10
    load(14'd1, 14'd1024, 14'd12288, 14'd3);
    run_pass(10, 1'b0);
    chk("k10_mem0", mem[0], 12277);
    chk("k10_mem1", mem[1], 1);

    // k=0 rewrites unchanged
    load(14'd5, 14'd7, 14'd9, 14'd11);
    run_pass(0, 1'b0);
    chk("k0_mem0", mem[0], 5);
    chk("k0_mem1", mem[1], 7);
    chk("k0_mem2", mem[2], 9);
    chk("k0_mem3", mem[3], 11);
    chk("k0_done_cycle", done_t, 12);

    // start and shift_cnt wiggled while busy
    load(rnd_coef(0), rnd_coef(0), rnd_coef(0), rnd_coef(0));
    run_pass(3, 1'b1);
    chk("noise_done_cycle", done_t, 24);

    // out-of-range word sets sticky err, pass completes
    load(14'd100, 14'd12289, 14'd7, 14'd8);
    run_pass(2, 1'b0);
    chk("err_after_pass", err, 1);
    chk("oor_mem0", mem[0], scale(100, 2));
    chk("oor_mem3", mem[3], scale(8, 2));
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);
    load(14'd4, 14'd6, 14'd8, 14'd10);
    run_pass(1, 1'b0);
    chk("err_cleared", err, 0);

    // reset during HALF of coefficient 2 (k=5: period 8, HALF at cycles 18..22)
    load(14'd11, 14'd22, 14'd33, 14'd44);
    kick(5);
    n = 0;
    while (t != 20 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_half2", t, 20);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_mem0", mem[0], scale(11, 5));
    chk("abort_mem1", mem[1], scale(22, 5));
    chk("abort_mem2", mem[2], 33);
    chk("abort_mem3", mem[3], 44);
    run_pass(7, 1'b0);
    chk("restart_mem2", mem[2], scale(33, 7));
    chk("restart_mem0", mem[0], scale(scale(11, 5), 7));

    // randomized passes
    for (int it = 0; it < 10; it++) begin
      kr = $urandom_range(0, 15);
      load(rnd_coef(1), rnd_coef(1), rnd_coef(1), rnd_coef(1));
      run_pass(kr, 1'($urandom_range(0, 1)));
      chk("rand_done_cycle", done_t, N * (3 + kr));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intt_half_scaler.md
INTT_HALF_SCALER -- requirements
Module: intt_half_scaler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, coefficient width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, coefficient address width; N = 2**ADDR_WIDTH coefficients.
REQ-003 SHALL have parameter Q, default 12289, modulus; (Q+1)/2 = 6145.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to scale the whole memory.
REQ-007 shift_cnt  input  4  number of halvings k (0..15) per coefficient.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at end of pass.
REQ-010 err  output  1  sticky out-of-range flag.
REQ-011 rd_en  output  1  memory read strobe.
REQ-012 rd_addr  output  ADDR_WIDTH  read address.
REQ-013 rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
REQ-014 wr_en  output  1  memory write strobe.
REQ-015 wr_addr  output  ADDR_WIDTH  write address.
REQ-016 wr_data  output  DATA_WIDTH  write data.

Function
REQ-017 SHALL multiply every coefficient in place by 2^-k mod Q, sequencing one modular-halving step per cycle.
REQ-018 Halving step SHALL be: x even -> x>>1; x odd -> (x>>1)+6145; result < Q for x < Q.
REQ-019 FSM states SHALL be IDLE, RD, CAP, HALF, WR, DONE.
REQ-020 IDLE: start=1 SHALL latch shift_cnt into k, clear idx to 0, clear err, go to RD.
REQ-021 RD: rd_en=1, rd_addr=idx for exactly one cycle; next CAP.
REQ-022 CAP: acc <= rd_data; err set if rd_data >= Q; remaining <= k; next HALF if k!=0 else WR.
REQ-023 HALF: acc <= half(acc), remaining decrements; exits to WR after exactly k cycles.
REQ-024 WR: wr_en=1, wr_addr=idx, wr_data=acc for one cycle; idx==N-1 -> DONE, else idx+1 -> RD.
REQ-025 DONE: done=1 for one cycle; next IDLE.
REQ-026 Per-coefficient cost SHALL be exactly 3+k cycles; done SHALL be high in the cycle beginning N*(3+k) rising edges after the edge that sampled start.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start while busy SHALL be ignored; shift_cnt changes while busy SHALL have no effect.
REQ-029 Out-of-range rd_data SHALL still be processed with the REQ-018 rule (result unspecified mod Q) and not abort the pass.
REQ-030 idx SHALL not wrap; exactly N reads and N writes per pass, addresses 0..N-1 ascending.
REQ-031 rd_en and wr_en SHALL never be high in the same cycle.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, idx=0, acc=0, k=0, and busy, done, err, rd_en, wr_en to 0; rd_addr, wr_addr, wr_data to 0.
REQ-033 rst mid-pass SHALL abandon the pass with no further writes; a new start after release SHALL begin at address 0.

Verification
REQ-034 ADDR_WIDTH=2, k=1, memory {1,2,12288,0} -> written {6145,1,6144,0}, done 16 cycles after start edge.
REQ-035 k=10, coefficient 1 -> 12277 (1024^-1 mod 12289); coefficient 1024 -> 1.
REQ-036 k=0, memory {5,7,9,11} -> unchanged values rewritten, 3 cycles per coefficient, done after 12.
REQ-037 start pulsed again and shift_cnt changed during busy -> pass unaffected, single done pulse.
REQ-038 rd_data=12289 on one address -> err=1 held until next accepted start; pass completes.
REQ-039 rst asserted during HALF of coefficient 2 -> all outputs 0 immediately, no write to address 2; restart completes full pass correctly.
